// File: rtl/axi_mem_slave.sv
// AXI-style memory responder: independent single-outstanding read and write
// state machines over an inferred RAM, fixed read latency, sticky error flag.
module axi_mem_slave #(
   parameter int ADDR_WIDTH   = 26,
   parameter int DATA_WIDTH   = 32,
   parameter int MEM_WORDS    = 16384,
   parameter int READ_LATENCY = 4,
   parameter     INIT_FILE    = ""
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  AWREADY,
   input  logic                  AWVALID,
   input  logic [3:0]            AWID,
   input  logic [3:0]            AWLEN,
   input  logic [ADDR_WIDTH-1:0] AWADDR,
   output logic                  WREADY,
   input  logic                  WVALID,
   input  logic                  WLAST,
   input  logic [3:0]            WID,
   input  logic [DATA_WIDTH-1:0] WDATA,
   input  logic                  BREADY,
   output logic                  BVALID,
   output logic [3:0]            BID,
   output logic                  ARREADY,
   input  logic                  ARVALID,
   input  logic [3:0]            ARID,
   input  logic [3:0]            ARLEN,
   input  logic [ADDR_WIDTH-1:0] ARADDR,
   input  logic                  RREADY,
   output logic                  RVALID,
   output logic                  RLAST,
   output logic [3:0]            RID,
   output logic [DATA_WIDTH-1:0] RDATA,
   output logic                  err
);

   localparam int IDX_W = $clog2(MEM_WORDS);
   localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} r_state_t;

   logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
   logic [DATA_WIDTH-1:0] mem_q;

   w_state_t w_state_reg, w_state_next;
   r_state_t r_state_reg, r_state_next;

   logic awready_reg, awready_next, wready_reg, wready_next, bvalid_reg, bvalid_next;
   logic arready_reg, arready_next, rvalid_reg, rvalid_next, rlast_reg, rlast_next;

   logic [3:0]       awid_reg, awlen_reg, wcnt_reg;
   logic [IDX_W-1:0] waddr_reg;
   logic [3:0]       arid_reg, arlen_reg, rcnt_reg, rcnt_next;
   logic [IDX_W-1:0] raddr_reg, raddr_next;
   logic [LAT_W-1:0] lat_reg;
   logic             err_reg;
   logic             rd_en;

   logic aw_hs, w_hs, b_hs, ar_hs, r_hs, w_last, r_last;
   logic unused_bits;

   assign aw_hs  = AWVALID && awready_reg;
   assign w_hs   = WVALID && wready_reg;
   assign b_hs   = BREADY && bvalid_reg;
   assign ar_hs  = ARVALID && arready_reg;
   assign r_hs   = RREADY && rvalid_reg;
   assign w_last = (wcnt_reg == awlen_reg);
   assign r_last = (rcnt_reg == arlen_reg);

   // Only the word-index bits of the byte addresses select storage.
   assign unused_bits = ^{AWADDR, ARADDR};

   // State and registered handshake outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w_state_reg <= W_IDLE;
         r_state_reg <= R_IDLE;
         awready_reg <= 1'b0;
         wready_reg  <= 1'b0;
         bvalid_reg  <= 1'b0;
         arready_reg <= 1'b0;
         rvalid_reg  <= 1'b0;
         rlast_reg   <= 1'b0;
         awid_reg    <= '0;
         awlen_reg   <= '0;
         wcnt_reg    <= '0;
         waddr_reg   <= '0;
         arid_reg    <= '0;
         arlen_reg   <= '0;
         rcnt_reg    <= '0;
         raddr_reg   <= '0;
         lat_reg     <= '0;
         err_reg     <= 1'b0;
      end else begin
         w_state_reg <= w_state_next;
         r_state_reg <= r_state_next;
         awready_reg <= awready_next;
         wready_reg  <= wready_next;
         bvalid_reg  <= bvalid_next;
         arready_reg <= arready_next;
         rvalid_reg  <= rvalid_next;
         rlast_reg   <= rlast_next;
         raddr_reg   <= raddr_next;
         rcnt_reg    <= rcnt_next;
         if (aw_hs) begin
            awid_reg  <= AWID;
            awlen_reg <= AWLEN;
            waddr_reg <= AWADDR[IDX_W+1:2];
            wcnt_reg  <= '0;
         end else if (w_hs) begin
            waddr_reg <= waddr_reg + 1'b1;
            wcnt_reg  <= wcnt_reg + 1'b1;
         end
         if (w_hs && ((WLAST != w_last) || (WID != awid_reg)))
            err_reg <= 1'b1;
         if (ar_hs) begin
            arid_reg  <= ARID;
            arlen_reg <= ARLEN;
            lat_reg   <= LAT_W'(READ_LATENCY - 1);
         end else if (r_state_reg == R_WAIT && lat_reg != '0) begin
            lat_reg <= lat_reg - 1'b1;
         end
      end
   end

   always_comb begin
      w_state_next = w_state_reg;
      case (w_state_reg)
         W_IDLE:  if (aw_hs) w_state_next = W_DATA;
         W_DATA:  if (w_hs && w_last) w_state_next = W_RESP;
         W_RESP:  if (b_hs) w_state_next = W_IDLE;
         default: w_state_next = W_IDLE;
      endcase
   end

   always_comb begin
      r_state_next = r_state_reg;
      case (r_state_reg)
         R_IDLE:  if (ar_hs) r_state_next = R_WAIT;
         R_WAIT:  if (lat_reg == '0) r_state_next = R_BURST;
         R_BURST: if (r_hs && r_last) r_state_next = R_IDLE;
         default: r_state_next = R_IDLE;
      endcase
   end

   // Output and read-datapath next values, decoded from the next state so
   // every handshake output leaves a flop.
   always_comb begin
      awready_next = (w_state_next == W_IDLE);
      wready_next  = (w_state_next == W_DATA);
      bvalid_next  = (w_state_next == W_RESP);
      arready_next = (r_state_next == R_IDLE);
      rvalid_next  = (r_state_next == R_BURST);
      raddr_next   = raddr_reg;
      rcnt_next    = rcnt_reg;
      if (ar_hs) begin
         raddr_next = ARADDR[IDX_W+1:2];
         rcnt_next  = '0;
      end else if (r_hs) begin
         raddr_next = raddr_reg + 1'b1;
         rcnt_next  = rcnt_reg + 1'b1;
      end
      rlast_next = (r_state_next == R_BURST) && (rcnt_next == arlen_reg);
      rd_en      = (r_state_next == R_BURST) && ((r_state_reg != R_BURST) || r_hs);
   end

   // A write accepted at one edge is seen by any read fetched at a later edge.
   always_ff @(posedge clk) begin
      if (w_hs)
         mem[waddr_reg] <= WDATA;
      if (rd_en)
         mem_q <= mem[raddr_next];
   end

   assign AWREADY = awready_reg;
   assign WREADY  = wready_reg;
   assign BVALID  = bvalid_reg;
   assign BID     = awid_reg;
   assign ARREADY = arready_reg;
   assign RVALID  = rvalid_reg;
   assign RLAST   = rlast_reg;
   assign RID     = arid_reg;
   assign RDATA   = rvalid_reg ? mem_q : '0;
   assign err     = err_reg;

endmodule

// File: tb/tb_axi_mem_slave.sv
// Bench for axi_mem_slave: directed vector table, hand-written corner cases
// and randomized bursts checked against an associative-array memory model.
module tb_axi_mem_slave;

   localparam int AW  = 26;
   localparam int DW  = 32;
   localparam int MW  = 16384;
   localparam int RL  = 4;
   localparam int TMO = 200;

   logic          clk = 1'b0;
   logic          rst;
   logic          AWREADY, AWVALID, WREADY, WVALID, WLAST, BREADY, BVALID;
   logic          ARREADY, ARVALID, RREADY, RVALID, RLAST, err;
   logic [3:0]    AWID, AWLEN, WID, BID, ARID, ARLEN, RID;
   logic [AW-1:0] AWADDR, ARADDR;
   logic [DW-1:0] WDATA, RDATA;

   always #5 clk = ~clk;

   axi_mem_slave #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_WORDS(MW), .READ_LATENCY(RL), .INIT_FILE("")
   ) dut (
      .clk(clk), .rst(rst),
      .AWREADY(AWREADY), .AWVALID(AWVALID), .AWID(AWID), .AWLEN(AWLEN), .AWADDR(AWADDR),
      .WREADY(WREADY), .WVALID(WVALID), .WLAST(WLAST), .WID(WID), .WDATA(WDATA),
      .BREADY(BREADY), .BVALID(BVALID), .BID(BID),
      .ARREADY(ARREADY), .ARVALID(ARVALID), .ARID(ARID), .ARLEN(ARLEN), .ARADDR(ARADDR),
      .RREADY(RREADY), .RVALID(RVALID), .RLAST(RLAST), .RID(RID), .RDATA(RDATA),
      .err(err)
   );

   typedef struct {
      logic [3:0]    id;
      logic [AW-1:0] addr;
      logic [3:0]    len;
      logic [31:0]   base;
      int            stall_beat;
      int            stall_n;
      logic [31:0]   exp_last;
   } vec_t;

   vec_t        vecs [6];
   int          checks = 0;
   int          failures = 0;
   logic [31:0] ref_mem [int];

   function automatic int widx(input logic [AW-1:0] a);
      return int'(a[AW-1:2]) % MW;
   endfunction

   function automatic logic sig_of(input int which);
      case (which)
         0:       return AWREADY;
         1:       return WREADY;
         2:       return BVALID;
         3:       return ARREADY;
         default: return RVALID;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic wait_for(input int which, input string name, output int n);
      n = 0;
      while (!sig_of(which) && n < TMO) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= TMO) check({name, "_timeout"}, 32'(sig_of(which)), 32'd1);
   endtask

   task automatic write_burst(input logic [3:0] id, input logic [AW-1:0] addr,
                              input logic [3:0] len, input logic [31:0] base,
                              input logic [31:0] step, input int wlast_idx,
                              input logic [3:0] wid_xor);
      int n;
      AWID = id; AWADDR = addr; AWLEN = len; AWVALID = 1'b1;
      wait_for(0, "awready", n);
      @(posedge clk); #1;
      AWVALID = 1'b0;
      for (int b = 0; b <= int'(len); b++) begin
         WDATA  = base + step * 32'(b);
         WID    = id ^ wid_xor;
         WLAST  = (b == wlast_idx);
         WVALID = 1'b1;
         wait_for(1, "wready", n);
         check("w_no_stall", 32'(n), 32'd0);
         @(posedge clk); #1;
         ref_mem[(widx(addr) + b) % MW] = WDATA;
         WVALID = 1'b0;
         WLAST  = 1'b0;
      end
      check("bvalid_next_cycle", 32'(BVALID), 32'd1);
      check("bid", 32'(BID), 32'(id));
      @(posedge clk); #1;
      check("bvalid_hold", 32'(BVALID), 32'd1);
      check("bid_hold", 32'(BID), 32'(id));
      BREADY = 1'b1;
      @(posedge clk); #1;
      BREADY = 1'b0;
      check("bvalid_drop", 32'(BVALID), 32'd0);
      check("awready_back", 32'(AWREADY), 32'd1);
      $display("WRITE id=%0d addr=0x%07h len=%0d base=0x%08h err=%0b", id, addr, len, base, err);
   endtask

   task automatic read_burst(input logic [3:0] id, input logic [AW-1:0] addr,
                             input logic [3:0] len, input int stall_beat,
                             input int stall_n, output logic [31:0] last);
      int n;
      int k;
      logic [31:0] exp;
      last = '0;
      ARID = id; ARADDR = addr; ARLEN = len; ARVALID = 1'b1;
      wait_for(3, "arready", n);
      @(posedge clk); #1;
      ARVALID = 1'b0;
      wait_for(4, "rvalid", n);
      check("r_latency", 32'(n), 32'(RL));
      for (int b = 0; b <= int'(len); b++) begin
         if (b > 0) begin
            wait_for(4, "rvalid", n);
            check("r_back2back", 32'(n), 32'd0);
         end
         k   = (widx(addr) + b) % MW;
         exp = ref_mem.exists(k) ? ref_mem[k] : 32'h0BAD0BAD;
         check("rdata", RDATA, exp);
         check("rlast", 32'(RLAST), 32'(b == int'(len)));
         check("rid", 32'(RID), 32'(id));
         if (b == stall_beat) begin
            RREADY = 1'b0;
            for (int s = 0; s < stall_n; s++) begin
               @(posedge clk); #1;
               check("rvalid_hold", 32'(RVALID), 32'd1);
               check("rdata_hold", RDATA, exp);
               check("rlast_hold", 32'(RLAST), 32'(b == int'(len)));
            end
         end
         last   = RDATA;
         RREADY = 1'b1;
         @(posedge clk); #1;
         RREADY = 1'b0;
      end
      check("rvalid_drop", 32'(RVALID), 32'd0);
      check("arready_back", 32'(ARREADY), 32'd1);
      $display("READ  id=%0d addr=0x%07h len=%0d last=0x%08h", id, addr, len, last);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: run still active at %0t, limit 1000000", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0]   last;
      logic [3:0]    rid, rlen, rnd_len;
      logic [AW-1:0] raddr;
      logic [31:0]   rbase, rstep;
      int            w, sb, sn, n;

      rst = 1'b1;
      AWVALID = 0; AWID = 0; AWLEN = 0; AWADDR = 0;
      WVALID = 0; WLAST = 0; WID = 0; WDATA = 0; BREADY = 0;
      ARVALID = 0; ARID = 0; ARLEN = 0; ARADDR = 0; RREADY = 0;

      vecs[0] = '{4'h1, 26'h0000040, 4'd0,  32'hDEADBEEF, -1, 0, 32'hDEADBEEF};
      vecs[1] = '{4'h2, 26'h0000100, 4'd3,  32'h00000001,  1, 2, 32'h00000004};
      vecs[2] = '{4'h3, 26'h000FFFC, 4'd1,  32'hA0000000, -1, 0, 32'hA0000001};
      vecs[3] = '{4'h4, 26'h0002000, 4'd15, 32'h00001000,  7, 3, 32'h0000100F};
      vecs[4] = '{4'h5, 26'h3FFFFF0, 4'd2,  32'h00000055,  0, 1, 32'h00000057};
      vecs[5] = '{4'hC, 26'h0001003, 4'd1,  32'h00000077, -1, 0, 32'h00000078};

      repeat (3) @(posedge clk);
      #1;
      check("reset_awready", 32'(AWREADY), 32'd0);
      check("reset_arready", 32'(ARREADY), 32'd0);
      check("reset_wready", 32'(WREADY), 32'd0);
      check("reset_bvalid", 32'(BVALID), 32'd0);
      check("reset_rvalid", 32'(RVALID), 32'd0);
      check("reset_rlast", 32'(RLAST), 32'd0);
      check("reset_rdata", RDATA, 32'd0);
      check("reset_err", 32'(err), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("awready_first_edge", 32'(AWREADY), 32'd1);
      check("arready_first_edge", 32'(ARREADY), 32'd1);
      $display("RESET released");

      foreach (vecs[i]) begin
         write_burst(vecs[i].id, vecs[i].addr, vecs[i].len, vecs[i].base, 32'd1,
                     int'(vecs[i].len), 4'h0);
         read_burst(vecs[i].id, vecs[i].addr, vecs[i].len, vecs[i].stall_beat,
                    vecs[i].stall_n, last);
         check("vec_last", last, vecs[i].exp_last);
      end

      // Burst from the last word lands its second beat in word 0.
      read_burst(4'h7, 26'h0000000, 4'd0, -1, 0, last);
      check("wrap_word0", last, 32'hA0000001);
      // Upper address bits alias onto the same storage.
      read_burst(4'h8, 26'h000FFF0, 4'd0, -1, 0, last);
      check("alias_word", last, 32'h00000055);

      // Read of word 0x10 launched alongside a write burst to the same word.
      fork
         write_burst(4'hD, 26'h0000040, 4'd3, 32'hC0DE0000, 32'd1, 3, 4'h0);
         begin
            read_burst(4'hE, 26'h0000040, 4'd0, -1, 0, last);
            check("collision_new_data", last, 32'hC0DE0000);
         end
      join

      for (int it = 0; it < 16; it++) begin
         rid     = 4'($urandom_range(15));
         rnd_len = 4'($urandom_range(15));
         w = ($urandom_range(3) == 0) ? (MW - 1 - int'($urandom_range(3)))
                                      : int'($urandom_range(MW - 1));
         raddr = AW'(w * 4 + int'($urandom_range(3)));
         raddr[AW-1:16] = 10'($urandom);
         rbase = $urandom;
         rstep = $urandom;
         rlen  = 4'($urandom_range(int'(rnd_len)));
         sb    = ($urandom_range(1) == 1) ? int'($urandom_range(int'(rlen))) : -1;
         sn    = int'($urandom_range(3, 1));
         write_burst(rid, raddr, rnd_len, rbase, rstep, int'(rnd_len), 4'h0);
         read_burst(rid ^ 4'hF, raddr, rlen, sb, sn, last);
      end
      check("err_clean", 32'(err), 32'd0);

      // Early WLAST: flag raised, burst still runs all four beats.
      write_burst(4'h9, 26'h0000500, 4'd3, 32'hE0000000, 32'd1, 0, 4'h0);
      check("err_wlast", 32'(err), 32'd1);
      read_burst(4'h9, 26'h0000500, 4'd3, -1, 0, last);
      check("err_burst_len", last, 32'hE0000003);
      check("err_sticky", 32'(err), 32'd1);

      // Reset asserted while beat 2 of a read burst is on the bus.
      ARID = 4'hA; ARADDR = 26'h0000100; ARLEN = 4'd3; ARVALID = 1'b1;
      wait_for(3, "arready", n);
      @(posedge clk); #1;
      ARVALID = 1'b0;
      wait_for(4, "rvalid", n);
      check("rst_beat1", RDATA, ref_mem[widx(26'h0000100)]);
      RREADY = 1'b1;
      @(posedge clk); #1;
      RREADY = 1'b0;
      check("rst_beat2_valid", 32'(RVALID), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("rst_rvalid_now", 32'(RVALID), 32'd0);
      check("rst_rdata_now", RDATA, 32'd0);
      check("rst_arready_now", 32'(ARREADY), 32'd0);
      check("rst_err_clear", 32'(err), 32'd0);
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      check("rst_arready_first_edge", 32'(ARREADY), 32'd1);
      check("rst_rvalid_idle", 32'(RVALID), 32'd0);
      $display("RESET mid-burst released");
      read_burst(4'hB, 26'h0000100, 4'd3, 2, 1, last);

      // Beat ID differing from the address ID.
      write_burst(4'h6, 26'h0000600, 4'd1, 32'h60000000, 32'd1, 1, 4'h3);
      check("err_wid", 32'(err), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
